ring_osc_freq_counter: RTL and testbench

Gated frequency counter that consumes the free-running ring-oscillator output and measures it against the system clock. It counts rising edges of the asynchronous oscillator signal over a programmable window of `clk` cycles. It then presents a saturating count with valid/overflow flags for readout on the tile's output pins. It sits directly downstream of the ring-oscillator stage, inside the same tile top level.

---
 rtl/ring_osc_freq_counter.sv | 114 +++++++++++
 tb/tb_ring_osc_freq_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_osc_freq_counter.sv
// Gated frequency counter: counts synchronized rising edges of an asynchronous
// ring-oscillator signal over a programmable window of clk cycles.
module ring_osc_freq_counter #(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              osc_in,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CNT_W-1:0]  count,
    output logic              valid,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [GATE_W-1:0]      win_ctr_q, win_ctr_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   overflow_q, overflow_d;

    logic                   rise;
    logic [CNT_W:0]         acc_next;

    // Returns {saturated, value}: value holds at all-ones instead of wrapping.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
        if (!inc)
            return {1'b0, a};
        else if (&a)
            return {1'b1, a};
        else
            return {1'b0, a + CNT_W'(1)};
    endfunction

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign acc_next = sat_inc(acc_q, rise);

    always_comb begin
        state_d    = state_q;
        // Front end runs in every state so prev is settled when a window opens.
        sync_d     = {sync_q[SYNC_STAGES-2:0], osc_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        win_ctr_d  = win_ctr_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start && (gate_len != '0)) begin
                    win_ctr_d = gate_len;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    valid_d   = 1'b0;
                    state_d   = MEASURE;
                end
            end
            MEASURE: begin
                acc_d     = acc_next[CNT_W-1:0];
                ovf_d     = ovf_q | acc_next[CNT_W];
                win_ctr_d = win_ctr_q - GATE_W'(1);
                // Last window cycle: publish including this cycle's edge.
                if (win_ctr_q == GATE_W'(1)) begin
                    count_d    = acc_next[CNT_W-1:0];
                    overflow_d = ovf_q | acc_next[CNT_W];
                    valid_d    = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            win_ctr_q  <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            win_ctr_q  <= win_ctr_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == MEASURE);

endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// Directed bench for ring_osc_freq_counter: a 16-bit instance and a 4-bit
// instance share the same stimulus so saturation can be exercised.
module tb_ring_osc_freq_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        osc_in = 1'b0;
    logic        start = 1'b0;
    logic [15:0] gate_len = '0;
    logic [15:0] count;
    logic        valid, overflow, busy;
    logic [3:0]  count_s;
    logic        valid_s, overflow_s, busy_s;

    int errors = 0;
    int checks = 0;

    int osc_period = 10;
    int osc_mode   = 0;   // 0 square wave, 1 held high, 2 held low
    int osc_ph     = 0;

    ring_osc_freq_counter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
        .count(count), .valid(valid), .overflow(overflow), .busy(busy)
    );

    ring_osc_freq_counter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_len(gate_len),
        .count(count_s), .valid(valid_s), .overflow(overflow_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    // Oscillator edges land 3 ns after a clk rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (osc_mode == 0) begin
                osc_ph = (osc_ph + 1) % osc_period;
                osc_in = (osc_ph < osc_period / 2);
            end else begin
                osc_in = (osc_mode == 1);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench 1 ns after the accepting edge E0.
    task automatic pulse_start(input logic [15:0] len);
        start    = 1'b1;
        gate_len = len;
        tick(1);
        start = 1'b0;
    endtask

    // Counts sampled busy cycles until busy falls; to=1 if the bound expires.
    task automatic wait_idle(output int n, output bit to);
        n  = 0;
        to = 1'b0;
        while (busy) begin
            if (n >= 1000) begin
                to = 1'b1;
                break;
            end
            n++;
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick(3);
        rst_n = 1'b1;
        tick(12);
    endtask

    task automatic test_nominal();
        int n; bit to;
        osc_mode = 0; osc_period = 10;
        tick(12);
        pulse_start(16'd100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_after_accept got=%b exp=1", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nom_valid_after_accept got=%b exp=0", valid); end
        wait_idle(n, to);
        checks++; if (to || n != 100) begin errors++; $display("FAIL nom_busy_len got=%0d exp=100 timeout=%0d", n, to); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL nom_valid got=%b exp=1", valid); end
        checks++; if (count !== 16'd10) begin errors++; $display("FAIL nom_count got=%0d exp=10", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL nom_overflow got=%b exp=0", overflow); end
        tick(5);
        checks++; if (valid !== 1'b1 || count !== 16'd10) begin errors++; $display("FAIL nom_hold got valid=%b count=%0d exp valid=1 count=10", valid, count); end
    endtask

    task automatic test_static();
        int n; bit to;
        for (int m = 1; m <= 2; m++) begin
            osc_mode = m;
            tick(10);
            pulse_start(16'd50);
            wait_idle(n, to);
            checks++; if (to || n != 50) begin errors++; $display("FAIL static%0d_len got=%0d exp=50", m, n); end
            checks++; if (valid !== 1'b1 || count !== 16'd0) begin errors++; $display("FAIL static%0d_result got valid=%b count=%0d exp valid=1 count=0", m, valid, count); end
        end
    endtask

    task automatic test_saturation();
        int n; bit to;
        osc_mode = 0; osc_period = 4;
        tick(12);
        pulse_start(16'd200);
        wait_idle(n, to);
        checks++; if (to || n != 200) begin errors++; $display("FAIL sat_len got=%0d exp=200", n); end
        checks++; if (count_s !== 4'd15) begin errors++; $display("FAIL sat_count got=%0d exp=15", count_s); end
        checks++; if (overflow_s !== 1'b1 || valid_s !== 1'b1) begin errors++; $display("FAIL sat_flags got ovf=%b valid=%b exp ovf=1 valid=1", overflow_s, valid_s); end
        checks++; if (count !== 16'd50 || overflow !== 1'b0) begin errors++; $display("FAIL sat_wide got count=%0d ovf=%b exp count=50 ovf=0", count, overflow); end
        osc_period = 20;
        tick(25);
        pulse_start(16'd100);
        checks++; if (overflow_s !== 1'b1 || count_s !== 4'd15 || valid_s !== 1'b0) begin errors++; $display("FAIL sat_hold_on_accept got ovf=%b count=%0d valid=%b exp ovf=1 count=15 valid=0", overflow_s, count_s, valid_s); end
        wait_idle(n, to);
        checks++; if (busy_s !== 1'b0 || count_s !== 4'd5 || overflow_s !== 1'b0) begin errors++; $display("FAIL sat_rerun got busy=%b count=%0d ovf=%b exp busy=0 count=5 ovf=0", busy_s, count_s, overflow_s); end
    endtask

    task automatic test_ignored();
        int n; bit to;
        osc_mode = 0; osc_period = 10;
        tick(25);
        pulse_start(16'd100);
        wait_idle(n, to);
        pulse_start(16'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy got=%b exp=0", busy); end
        tick(3);
        checks++; if (busy !== 1'b0 || valid !== 1'b1 || count !== 16'd10) begin errors++; $display("FAIL zero_len_hold got busy=%b valid=%b count=%0d exp busy=0 valid=1 count=10", busy, valid, count); end
        pulse_start(16'd100);
        n  = 0;
        to = 1'b0;
        while (busy) begin
            if (n >= 1000) begin to = 1'b1; break; end
            start    = (n == 20);
            gate_len = (n >= 20) ? 16'd7 : 16'd100;
            n++;
            tick(1);
        end
        start = 1'b0;
        checks++; if (to || n != 100) begin errors++; $display("FAIL midwin_len got=%0d exp=100", n); end
        checks++; if (valid !== 1'b1 || count !== 16'd10) begin errors++; $display("FAIL midwin_result got valid=%b count=%0d exp valid=1 count=10", valid, count); end
        tick(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midwin_no_restart got busy=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int n; bit to;
        start    = 1'b1;
        gate_len = 16'd20;
        tick(1);
        wait_idle(n, to);
        checks++; if (to || n != 20 || count !== 16'd2 || valid !== 1'b1) begin errors++; $display("FAIL b2b_first got len=%0d count=%0d valid=%b exp len=20 count=2 valid=1", n, count, valid); end
        tick(1);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got busy=%b valid=%b exp busy=1 valid=0", busy, valid); end
        wait_idle(n, to);
        checks++; if (to || n != 20 || count !== 16'd2 || valid !== 1'b1) begin errors++; $display("FAIL b2b_second got len=%0d count=%0d valid=%b exp len=20 count=2 valid=1", n, count, valid); end
    endtask

    task automatic test_abort();
        int n; bit to;
        pulse_start(16'd100);
        tick(29);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 16'd0 || valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_outputs got count=%0d valid=%b ovf=%b busy=%b exp all 0", count, valid, overflow, busy); end
        tick(3);
        checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL abort_held got busy=%b valid=%b exp 0", busy, valid); end
        rst_n = 1'b1;
        tick(12);
        checks++; if (valid !== 1'b0 || count !== 16'd0) begin errors++; $display("FAIL abort_no_result got valid=%b count=%0d exp 0", valid, count); end
        pulse_start(16'd100);
        wait_idle(n, to);
        checks++; if (to || n != 100 || count !== 16'd10 || valid !== 1'b1) begin errors++; $display("FAIL abort_recover got len=%0d count=%0d valid=%b exp len=100 count=10 valid=1", n, count, valid); end
    endtask

    initial begin
        #1;
        test_reset();
        test_nominal();
        test_static();
        test_saturation();
        test_ignored();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
